// File: rtl/mem_access_unit.sv
// Load/store unit: turns one CPU byte/halfword/word request into single-word RAM accesses.
// Latency: error 1 cycle, load and word store 2, sub-word store 3 (read-modify-write) to resp_valid.
// Backpressure: one request in flight; req_ready low until resp_ready is seen high in RESP.
module mem_access_unit #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] ram_address,
  output logic [31:0] ram_writedata,
  output logic        ram_load,
  input  logic [31:0] ram_out
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  // Request fields kept for the life of the transaction; the word index lives in ram_address.
  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  off;
    logic [31:0] wdata;
  } req_t;

  state_t      state;
  req_t        cur;
  logic        bad_req;
  logic [4:0]  shift;
  logic [31:0] lane_mask;
  logic [15:0] lane_val;
  logic [31:0] load_val;
  logic [31:0] merged;

  // Reserved size and misaligned halfword/word requests are rejected at the accept edge.
  always_comb begin
    bad_req = 1'b0;
    case (req_size)
      2'b01:   bad_req = req_addr[0];
      2'b10:   bad_req = (req_addr[1:0] != 2'b00);
      2'b11:   bad_req = 1'b1;
      default: bad_req = 1'b0;
    endcase
  end

  // Bit position of the addressed lane; big-endian puts offset 0 in the top byte.
  always_comb begin
    shift = 5'd0;
    case (cur.size)
      2'b00:   shift = BIG_ENDIAN ? {~cur.off, 3'b000} : {cur.off, 3'b000};
      2'b01:   shift = BIG_ENDIAN ? {~cur.off[1], 4'b0000} : {cur.off[1], 4'b0000};
      default: shift = 5'd0;
    endcase
  end

  // Lane extraction with sign/zero extension for loads, and lane merge for sub-word stores.
  always_comb begin
    lane_mask = (cur.size == 2'b00) ? (32'h0000_00ff << shift) : (32'h0000_ffff << shift);
    lane_val  = 16'(ram_out >> shift);
    load_val  = ram_out;
    case (cur.size)
      2'b00:   load_val = {{24{cur.sgn & lane_val[7]}}, lane_val[7:0]};
      2'b01:   load_val = {{16{cur.sgn & lane_val[15]}}, lane_val[15:0]};
      default: load_val = ram_out;
    endcase
    merged = (ram_out & ~lane_mask) | ((cur.wdata << shift) & lane_mask);
  end

  // Transaction FSM; every interface output is a register so ram_load cannot glitch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cur           <= '0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= 32'd0;
      resp_error    <= 1'b0;
      ram_load      <= 1'b0;
      ram_address   <= 32'd0;
      ram_writedata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cur         <= {req_write, req_size, req_signed, req_addr[1:0], req_wdata};
            ram_address <= {2'b00, req_addr[31:2]};
            req_ready   <= 1'b0;
            if (bad_req) begin
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= 32'd0;
              state      <= RESP;
            end else if (req_write && req_size == 2'b10) begin
              // Full-word store needs no read of the old contents.
              ram_writedata <= req_wdata;
              ram_load      <= 1'b1;
              state         <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (cur.write) begin
            ram_writedata <= merged;
            ram_load      <= 1'b1;
            state         <= WRITE;
          end else begin
            resp_rdata <= load_val;
            resp_error <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WRITE: begin
          ram_load   <= 1'b0;
          resp_rdata <= 32'd0;
          resp_error <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-addressed reference memory, response scoreboard, RAM write monitor.
// Latency: checked per transaction in the driver against the reference model's expectation.
// Backpressure: resp_ready is driven early (before RESP), late, or held off for several cycles.
module tb_mem_access_unit;

  localparam bit BE = 1'b1;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] ram_address, ram_writedata, ram_out;
  logic        ram_load;

  logic [31:0] ram [256];
  logic [7:0]  mb  [1024];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          pulses = 0;
  logic [31:0] last_wdata, last_waddr;

  mem_access_unit #(.BIG_ENDIAN(BE)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .ram_address(ram_address), .ram_writedata(ram_writedata), .ram_load(ram_load), .ram_out(ram_out)
  );

  always #5 clock = ~clock;

  assign ram_out = ram[ram_address[7:0]];

  always @(posedge clock) if (ram_load) ram[ram_address[7:0]] <= ram_writedata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // RAM write monitor
  always @(negedge clock) begin
    if (ram_load) begin
      pulses++;
      last_wdata = ram_writedata;
      last_waddr = ram_address;
    end
  end

  // Response monitor: one pop per response handshake
  always @(negedge clock) begin
    if (!reset && resp_valid && resp_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got response 0x%08h err %0d, expected none", resp_rdata, resp_error);
      end else begin
        mon_e = sbq.pop_front();
        check("resp_rdata", resp_rdata, mon_e.rdata);
        check("resp_error", {31'b0, resp_error}, {31'b0, mon_e.err});
      end
    end
  end

  // Reference model over a byte array: the memory as the CPU sees it.
  task automatic model(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                       input logic [31:0] wd, output logic err, output logic [31:0] rd,
                       output int lat, output int nwr);
    int n;
    int a;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    a   = int'(addr[9:0]);
    rd  = 32'd0;
    nwr = 0;
    lat = 1;
    if (n == 0) err = 1'b1;
    else        err = ((a % n) != 0);
    if (err) begin
      lat = 1;
    end else if (!wr) begin
      for (int i = 0; i < n; i++)
        rd = BE ? ((rd << 8) | 32'(mb[a + i])) : (rd | (32'(mb[a + i]) << (8 * i)));
      if (sg && n < 4 && rd[8 * n - 1]) rd = rd | (32'hFFFF_FFFF << (8 * n));
      lat = 2;
    end else begin
      for (int i = 0; i < n; i++)
        mb[a + i] = BE ? 8'(wd >> (8 * (n - 1 - i))) : 8'(wd >> (8 * i));
      lat = (n == 4) ? 2 : 3;
      nwr = 1;
    end
  endtask

  function automatic logic [31:0] model_word(input int w);
    if (BE) return {mb[4*w], mb[4*w+1], mb[4*w+2], mb[4*w+3]};
    else    return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
  endfunction

  task automatic print_summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold, input bit eager, input bit noisy,
                        input string tag);
    logic        err;
    logic [31:0] rd, rd0;
    logic        er0;
    int          lat_exp, nwr, lat;
    bit          stable;
    exp_t        e;
    model(wr, sz, sg, addr, wd, err, rd, lat_exp, nwr);
    e.rdata = rd;
    e.err   = err;
    sbq.push_back(e);

    @(negedge clock);
    check({tag, "_req_ready_idle"}, {31'b0, req_ready}, 32'd1);
    pulses     = 0;
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clock);
    #1;
    if (noisy) begin
      req_write  = 1'($urandom);
      req_size   = 2'($urandom);
      req_signed = 1'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
    end else begin
      req_valid = 1'b0;
    end
    if (eager) resp_ready = 1'b1;

    lat = 0;
    do begin
      @(negedge clock);
      lat++;
      if (lat == 1) check({tag, "_ram_address"}, ram_address, {2'b00, addr[31:2]});
    end while (!resp_valid && lat < 20);
    check({tag, "_latency"}, lat, lat_exp);
    if (!resp_valid) begin
      $display("FAIL %s_timeout: got no resp_valid within 20 cycles, expected %0d", tag, lat_exp);
      print_summary();
      $fatal(1);
    end

    if (!eager) begin
      rd0    = resp_rdata;
      er0    = resp_error;
      stable = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(negedge clock);
        if (!(resp_valid && resp_rdata === rd0 && resp_error === er0 && !req_ready)) stable = 1'b0;
      end
      if (hold > 0) check({tag, "_hold_stable"}, {31'b0, stable}, 32'd1);
      @(posedge clock);
      #1 resp_ready = 1'b1;
    end
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    @(negedge clock);
    check({tag, "_req_ready_after"}, {31'b0, req_ready}, 32'd1);
    check({tag, "_ram_pulses"}, pulses, nwr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion");
    print_summary();
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    bit          ok;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      w = (i == 4) ? 32'hDEAD_BEEF : $urandom;
      ram[i] = w;
      for (int k = 0; k < 4; k++) mb[4*i + k] = BE ? w[31 - 8*k -: 8] : w[8*k +: 8];
    end

    repeat (2) @(posedge clock);
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_error", {31'b0, resp_error}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_ram_load", {31'b0, ram_load}, 32'd0);
    check("rst_ram_address", ram_address, 32'd0);
    check("rst_ram_writedata", ram_writedata, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Directed cases
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 1'b0, 1'b0, "lw");
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 0, 1'b0, 1'b0, "lb");
    do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 0, 1'b1, 1'b0, "lbu");
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0, 1'b0, 1'b1, "lhu");
    do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h55, 0, 1'b0, 1'b0, "sb");
    check("sb_writedata", last_wdata, 32'hDEAD_BE55);
    check("sb_waddr", last_waddr, 32'd4);
    do_req(1'b1, 2'b10, 1'b0, 32'h06, 32'hCAFE_F00D, 0, 1'b0, 1'b0, "sw_misaligned");
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0, 1'b0, 1'b0, "size11");
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5, 1'b0, 1'b0, "hold");
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0, 0, 1'b0, 1'b0, "lw_top");
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_A5C3, 1, 1'b0, 1'b0, "sh");
    do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 0, 1'b0, 1'b0, "lh");

    // Reset in the WRITE cycle of a word store
    @(negedge clock);
    pulses     = 0;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_size   = 2'b10;
    req_signed = 1'b0;
    req_addr   = 32'h30;
    req_wdata  = 32'h1234_5678;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    check("rst_abort_pulse_pre", {31'b0, ram_load}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_abort_ram_load", {31'b0, ram_load}, 32'd0);
    check("rst_abort_req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clock);
    #1;
    check("rst_abort_ram_word", ram[12], model_word(12));
    check("rst_abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_abort_idle", {31'b0, req_ready}, 32'd1);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), 32'($urandom_range(0, 1023)),
             $urandom, $urandom_range(0, 3), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             "rand");
    end

    repeat (2) @(negedge clock);
    ok = 1'b1;
    for (int i = 0; i < 256; i++) if (ram[i] !== model_word(i)) ok = 1'b0;
    check("ram_final", {31'b0, ok}, 32'd1);
    check("sb_drained", sbq.size(), 32'd0);
    print_summary();
    $finish;
  end

endmodule
